hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised successor to the pipeline stall unit. It records each issued instruction's destination and Tnew in an internal E/M scoreboard, so E/M instructions are not re-decoded. It also tracks a multi-cycle multiply/divide unit (MDU) with a countdown timer. It sits beside the D stage and drives the pipeline freeze (F/D hold) and the E-stage bubble.

## Interface
Parameters:
- ADDR_W, 5, register address width
- T_W, 2, width of Tuse/Tnew fields; all-ones encodes "not used / never"
- MULT_CYC, 5, MDU busy cycles for mult/multu
- DIV_CYC, 10, MDU busy cycles for div/divu
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; one clock, all state on rising edge of clk
- D_rs_addr, D_rt_addr  in  ADDR_W  D-stage source registers
- D_Tuse_rs, D_Tuse_rt  in  T_W  cycles until D needs the operand (0 = branch/jr)
- D_A3  in  ADDR_W  D-stage destination (0 = no write)
- D_Tnew  in  T_W  cycles after entering E until result is ready (calc=1, load=2, jal=0)
- D_md_start  in  1  D is mult/multu/div/divu
- D_md_div  in  1  with D_md_start, selects DIV_CYC
- D_md_use  in  1  D is mfhi/mflo/mthi/mtlo/mult/multu/div/divu
- stall  out  1  hold PC and F/D register
- E_flush  out  1  insert bubble into D/E register (equals stall)
- E_A3, M_A3  out  ADDR_W  scoreboard destinations (for forwarding mux)
- E_Tnew, M_Tnew  out  T_W  current remaining Tnew per stage
- md_busy  out  1  MDU countdown nonzero
- stall_cnt  out  CNT_W  stall cycle count (see Configuration)

## Operation
- Scoreboard slots E{A3, Tnew, md} and M{A3, Tnew}.
- Each cycle, not in reset:
  - M slot <= {E_A3, E_Tnew saturating-decremented by 1, floor 0}.
  - E slot <= {0, 0, 0} if stall.
  - Otherwise E slot <= {D_A3, D_Tnew, D_md_start & D_md_div-select}.
  - When D_A3 = 0, stored Tnew is forced to 0.
- Data-hazard stall, per stage S in {E, M} and source X in {rs, rt}: stall when S_A3 == D_X_addr, D_X_addr != 0, and S_Tnew > D_Tuse_X (unsigned). Tuse all-ones never stalls.
- MDU countdown md_cnt, width = clog2(max(MULT_CYC, DIV_CYC)+1):
  - Loads MULT_CYC or DIV_CYC on the cycle after an E slot with md = 1.
  - Otherwise decrements while nonzero.
  - md_busy = (md_cnt != 0).
- MDU stall: D_md_use & (E slot md | md_busy).
- stall = OR of all four data terms and the MDU term. Purely combinational from D inputs and current state.
- No downstream backpressure: M slot always advances.

## Timing
- Reset values: E/M slots 0, md_cnt 0, stall 0, E_flush 0, md_busy 0, stall_cnt 0.
- stall is valid in the same cycle as the D inputs; zero-latency combinational path.
- Scoreboard and counter update at the rising edge after the inputs are sampled.
- A mult in E at cycle t gives md_busy high from t+1 through t+MULT_CYC. A dependent mflo in D stalls at t..t+MULT_CYC and issues at t+MULT_CYC+1.
- Stalled D instruction is never recorded. Its bubble enters E with A3 = 0.
- Reset mid-MDU operation clears md_cnt immediately; the next cycle has no MDU stall.
- Simultaneous E and M match on the same register: either stalls. Forwarding priority is the consumer's job (E over M).

## Configuration
- STALL_PERF_CNT_EN defined:
  - stall_cnt increments by 1 each cycle stall = 1.
  - Saturates at 2^CNT_W-1.
  - Cleared by reset.
- Not defined: stall_cnt is constant 0; no counter flops are synthesised. The port remains.

## Test plan
- Load-use: issue lw $8 (D_A3=8, Tnew=2), then add with rs=8 (Tuse_rs=1) -> stall=1 for exactly 1 cycle, E_A3=0 bubble, add issues next cycle.
- Branch after calc: addu $3, then beq rs=3 (Tuse=0):
  - E_Tnew=1 -> stall 1 cycle.
  - Then M_Tnew=0 -> no stall.
- $0 guard: lw $0 then add rs=0 -> stall never asserted.
- MDU: mult (MULT_CYC=5), then mflo:
  - md_busy high 5 cycles.
  - mflo stalls 6 cycles total (E-md cycle + 5).
  - div (DIV_CYC=10) variant stalls 11.
- Reset mid-div: assert reset at md_cnt=4 -> next cycle md_busy=0, stall=0, scoreboard zeroed.
- With STALL_PERF_CNT_EN, run the load-use plus mult sequences -> stall_cnt = 7. Without the macro -> stall_cnt = 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
// Groups the D-stage hazard inputs and the hazard-unit outputs into one bundle.
//   master : pipeline side, drives the D-stage instruction fields and observes
//            stall / E_flush / scoreboard contents / MDU busy / stall counter.
//   slave  : hazard_scoreboard side.
// Signals:
//   D_rs_addr, D_rt_addr   source registers of the instruction in D
//   D_Tuse_rs, D_Tuse_rt   cycles until D needs each operand (all-ones = never)
//   D_A3, D_Tnew           destination and result latency of the D instruction
//   D_md_start, D_md_div   D starts an MDU operation (div selects long latency)
//   D_md_use               D touches HI/LO or the MDU
//   stall, E_flush         freeze F/D, bubble into D/E
//   E_A3, M_A3             scoreboard destinations
//   E_Tnew, M_Tnew         remaining result latency per stage
//   md_busy                MDU still counting down
//   stall_cnt              stall cycle counter
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
   parameter int ADDR_W = 5,
   parameter int T_W    = 2,
   parameter int CNT_W  = 32
);
   logic [ADDR_W-1:0] D_rs_addr;
   logic [ADDR_W-1:0] D_rt_addr;
   logic [T_W-1:0]    D_Tuse_rs;
   logic [T_W-1:0]    D_Tuse_rt;
   logic [ADDR_W-1:0] D_A3;
   logic [T_W-1:0]    D_Tnew;
   logic              D_md_start;
   logic              D_md_div;
   logic              D_md_use;
   logic              stall;
   logic              E_flush;
   logic [ADDR_W-1:0] E_A3;
   logic [ADDR_W-1:0] M_A3;
   logic [T_W-1:0]    E_Tnew;
   logic [T_W-1:0]    M_Tnew;
   logic              md_busy;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output D_rs_addr, D_rt_addr, D_Tuse_rs, D_Tuse_rt, D_A3, D_Tnew,
             D_md_start, D_md_div, D_md_use,
      input  stall, E_flush, E_A3, M_A3, E_Tnew, M_Tnew, md_busy, stall_cnt
   );

   modport slave (
      input  D_rs_addr, D_rt_addr, D_Tuse_rs, D_Tuse_rt, D_A3, D_Tnew,
             D_md_start, D_md_div, D_md_use,
      output stall, E_flush, E_A3, M_A3, E_Tnew, M_Tnew, md_busy, stall_cnt
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Stall unit sitting beside the D stage. Keeps a two-entry scoreboard (E, M)
// holding destination register and remaining Tnew of the instructions already
// issued, plus a countdown timer for the multi-cycle multiply/divide unit.
// From the D-stage Tuse/addresses and the scoreboard it decides, in the same
// cycle, whether D must be held (stall) and a bubble injected into E (E_flush).
// Ports:
//   clk     clock
//   reset   synchronous active-high reset
//   bus     hazard_scoreboard_if.slave (D inputs in, stall/scoreboard out)
// Optional feature:
//   STALL_PERF_CNT_EN  when defined, stall_cnt counts stalled cycles
//                      (saturating); otherwise stall_cnt is tied to zero.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int ADDR_W   = 5,
   parameter int T_W      = 2,
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CNT_W    = 32
) (
   input logic               clk,
   input logic               reset,
   hazard_scoreboard_if.slave bus
);
   localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int MD_W   = $clog2(MD_MAX + 1);

   localparam logic [ADDR_W-1:0] A_ZERO    = {ADDR_W{1'b0}};
   localparam logic [T_W-1:0]    T_ZERO    = {T_W{1'b0}};
   localparam logic [T_W-1:0]    T_ONE     = T_W'(1'b1);
   localparam logic [T_W-1:0]    T_NEVER   = {T_W{1'b1}};
   localparam logic [MD_W-1:0]   MD_ZERO   = {MD_W{1'b0}};
   localparam logic [MD_W-1:0]   MD_ONE    = MD_W'(1'b1);
   localparam logic [MD_W-1:0]   MULT_LOAD = MD_W'(MULT_CYC);
   localparam logic [MD_W-1:0]   DIV_LOAD  = MD_W'(DIV_CYC);

   // Scoreboard slots and MDU timer
   logic [ADDR_W-1:0] e_a3_r;
   logic [T_W-1:0]    e_tnew_r;
   logic              e_md_r;
   logic              e_div_r;
   logic [ADDR_W-1:0] m_a3_r;
   logic [T_W-1:0]    m_tnew_r;
   logic [MD_W-1:0]   md_cnt_r;

   logic              md_busy_s;
   logic              data_stall_s;
   logic              md_stall_s;
   logic              stall_s;

   // A producer blocks a consumer only if it writes the same non-zero register
   // and its result arrives later than the consumer needs it.
   function automatic logic hazard_f(
      input logic [ADDR_W-1:0] src_addr,
      input logic [T_W-1:0]    tuse,
      input logic [ADDR_W-1:0] slot_a3,
      input logic [T_W-1:0]    slot_tnew
   );
      logic hit;
      hit = (slot_a3 == src_addr) && (src_addr != A_ZERO) &&
            (tuse != T_NEVER) && (slot_tnew > tuse);
      return hit;
   endfunction

   assign md_busy_s = (md_cnt_r != MD_ZERO);

   // Zero-latency stall decision from the D inputs and current scoreboard
   always_comb begin
      data_stall_s = 1'b0;
      md_stall_s   = 1'b0;
      stall_s      = 1'b0;
      data_stall_s = hazard_f(bus.D_rs_addr, bus.D_Tuse_rs, e_a3_r, e_tnew_r) |
                     hazard_f(bus.D_rt_addr, bus.D_Tuse_rt, e_a3_r, e_tnew_r) |
                     hazard_f(bus.D_rs_addr, bus.D_Tuse_rs, m_a3_r, m_tnew_r) |
                     hazard_f(bus.D_rt_addr, bus.D_Tuse_rt, m_a3_r, m_tnew_r);
      // The MDU is unavailable both while its start is sitting in E and while
      // the countdown is running.
      md_stall_s   = bus.D_md_use & (e_md_r | md_busy_s);
      stall_s      = data_stall_s | md_stall_s;
   end

   // Scoreboard advance: E ages into M, D (or a bubble) enters E
   always_ff @(posedge clk) begin
      if (reset) begin
         e_a3_r   <= A_ZERO;
         e_tnew_r <= T_ZERO;
         e_md_r   <= 1'b0;
         e_div_r  <= 1'b0;
         m_a3_r   <= A_ZERO;
         m_tnew_r <= T_ZERO;
      end else begin
         m_a3_r   <= e_a3_r;
         m_tnew_r <= (e_tnew_r == T_ZERO) ? T_ZERO : (e_tnew_r - T_ONE);
         if (stall_s) begin
            e_a3_r   <= A_ZERO;
            e_tnew_r <= T_ZERO;
            e_md_r   <= 1'b0;
            e_div_r  <= 1'b0;
         end else begin
            e_a3_r   <= bus.D_A3;
            // A non-writing instruction can never be a producer.
            e_tnew_r <= (bus.D_A3 == A_ZERO) ? T_ZERO : bus.D_Tnew;
            e_md_r   <= bus.D_md_start;
            e_div_r  <= bus.D_md_start & bus.D_md_div;
         end
      end
   end

   // MDU countdown, loaded when the MDU start leaves E
   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_r <= MD_ZERO;
      end else if (e_md_r) begin
         md_cnt_r <= e_div_r ? DIV_LOAD : MULT_LOAD;
      end else if (md_cnt_r != MD_ZERO) begin
         md_cnt_r <= md_cnt_r - MD_ONE;
      end else begin
         md_cnt_r <= MD_ZERO;
      end
   end

   assign bus.stall   = stall_s;
   assign bus.E_flush = stall_s;
   assign bus.E_A3    = e_a3_r;
   assign bus.M_A3    = m_a3_r;
   assign bus.E_Tnew  = e_tnew_r;
   assign bus.M_Tnew  = m_tnew_r;
   assign bus.md_busy = md_busy_s;

`ifdef STALL_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [CNT_W-1:0] stall_cnt_r;

   // Saturating count of stalled cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_r <= CNT_ZERO;
      end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign bus.stall_cnt = stall_cnt_r;
`else
   assign bus.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule
